// File: rtl/ioc_bus_master.sv
// ioc_bus_master: single-beat IOC podule-bus initiator.
// Converts read/write commands into select/strobe bus cycles with programmable
// setup, strobe and hold timing. The target can stretch the strobe with gt, and
// a timeout bounds that stretch. Every bus output comes straight from a flop.
module ioc_bus_master #(
    parameter int SETUP   = 2,   // clocks from select low to strobe low (>= 1)
    parameter int STROBE  = 4,   // minimum strobe-low clocks (>= 3)
    parameter int HOLD    = 2,   // clocks from strobe release to select release (>= 1)
    parameter int TIMEOUT = 64   // maximum strobe-low clocks while gt is low (>= STROBE)
) (
    input  logic        clk,
    input  logic        reset,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [11:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    // response side
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    // IOC bus
    output logic [11:0] a,
    output logic        nioc_sel,
    output logic        rnw,
    output logic        nre,
    output logic        nwe,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    input  logic        gt
);

    localparam int MAX_SS  = (SETUP > STROBE) ? SETUP : STROBE;
    localparam int MAX_HT  = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
    localparam int MAX_ALL = (MAX_SS > MAX_HT) ? MAX_SS : MAX_HT;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] SETUP_M1   = CW'(SETUP - 1);
    localparam logic [CW-1:0] STROBE_M1  = CW'(STROBE - 1);
    localparam logic [CW-1:0] HOLD_M1    = CW'(HOLD - 1);
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [11:0]   a_q, a_d;
    logic [7:0]    d_out_q, d_out_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          timeout_q, timeout_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          nioc_sel_q, nioc_sel_d;
    logic          rnw_q, rnw_d;
    logic          nre_q, nre_d;
    logic          nwe_q, nwe_d;
    logic          d_oe_q, d_oe_d;

    // Next-state, counter and registered-output computation for the bus cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        a_d         = a_q;
        d_out_d     = d_out_q;
        rdata_d     = rdata_q;
        timeout_d   = timeout_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    a_d     = cmd_addr;
                    d_out_d = cmd_wdata;
                    cnt_d   = SETUP_M1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STROBE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q >= STROBE_M1 && gt) begin
                    // Final strobe-low edge: the target data is valid here.
                    if (!write_q) rdata_d = d_in;
                    timeout_d = 1'b0;
                    cnt_d     = HOLD_M1;
                    state_d   = ST_HOLD;
                end else if (cnt_q == TIMEOUT_M1 && !gt) begin
                    if (!write_q) rdata_d = 8'hFF;
                    timeout_d = 1'b1;
                    cnt_d     = HOLD_M1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus controls are decoded from the state being entered so they can be registered.
        cmd_ready_d = (state_d == ST_IDLE);
        nioc_sel_d  = (state_d == ST_IDLE);
        rnw_d       = (state_d == ST_IDLE) || !write_d;
        d_oe_d      = (state_d != ST_IDLE) && write_d;
        nre_d       = !((state_d == ST_STROBE) && !write_d);
        nwe_d       = !((state_d == ST_STROBE) && write_d);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            a_q         <= '0;
            d_out_q     <= '0;
            rdata_q     <= '0;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            nioc_sel_q  <= 1'b1;
            rnw_q       <= 1'b1;
            nre_q       <= 1'b1;
            nwe_q       <= 1'b1;
            d_oe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            a_q         <= a_d;
            d_out_q     <= d_out_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            nioc_sel_q  <= nioc_sel_d;
            rnw_q       <= rnw_d;
            nre_q       <= nre_d;
            nwe_q       <= nwe_d;
            d_oe_q      <= d_oe_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = timeout_q;
    assign a           = a_q;
    assign nioc_sel    = nioc_sel_q;
    assign rnw         = rnw_q;
    assign nre         = nre_q;
    assign nwe         = nwe_q;
    assign d_out       = d_out_q;
    assign d_oe        = d_oe_q;

endmodule

// File: tb/tb_ioc_bus_master.sv
// Directed bench for ioc_bus_master with default timing parameters.
// "Cycle k" is the value observed just before clock edge k, where edge 0 accepts the command.
module tb_ioc_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [11:0] a;
    logic        nioc_sel;
    logic        rnw;
    logic        nre;
    logic        nwe;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        gt;

    int tests_run    = 0;
    int tests_failed = 0;

    ioc_bus_master dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .a           (a),
        .nioc_sel    (nioc_sel),
        .rnw         (rnw),
        .nre         (nre),
        .nwe         (nwe),
        .d_out       (d_out),
        .d_oe        (d_oe),
        .d_in        (d_in),
        .gt          (gt)
    );

    always #5 clk = ~clk;

    // Issues one command from IDLE (call at a negedge) and observes it at each negedge.
    // gt is held low for the first gt_low_n strobe clocks, then driven high.
    task automatic run_cmd(input logic wr, input logic [11:0] addr, input logic [7:0] wdata,
                           input logic [7:0] din, input int gt_low_n,
                           output int strobe_len, output int rsp_cycle, output int sel_fall,
                           output logic [7:0] rdata, output logic tout,
                           output logic stable_ok, output logic ready_ok);
        strobe_len = 0;
        rsp_cycle  = -1;
        sel_fall   = -1;
        rdata      = 8'hxx;
        tout       = 1'bx;
        stable_ok  = 1'b1;
        ready_ok   = 1'b0;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        d_in       = din;
        gt         = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (!nre || !nwe) strobe_len++;
            if (!nioc_sel && sel_fall < 0) sel_fall = k;
            if (!nioc_sel) begin
                if (a !== addr || rnw !== !wr || d_oe !== wr) stable_ok = 1'b0;
                if (wr && d_out !== wdata) stable_ok = 1'b0;
                if (wr ? !nre : !nwe) stable_ok = 1'b0;
            end
            gt = (strobe_len == 0) ? 1'b1 : (strobe_len > gt_low_n);
            if (rsp_valid) begin
                rsp_cycle = k;
                rdata     = rsp_rdata;
                tout      = rsp_timeout;
                ready_ok  = cmd_ready;
                break;
            end
        end
        gt = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 12'h000;
        cmd_wdata = 8'h00;
        d_in      = 8'h00;
        gt        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({cmd_ready, nioc_sel, nre, nwe, rnw, d_oe, rsp_valid, rsp_timeout} !== 8'b1111_1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 11111000",
                     {cmd_ready, nioc_sel, nre, nwe, rnw, d_oe, rsp_valid, rsp_timeout});
        end
        tests_run++;
        if ({a, d_out, rsp_rdata} !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got a=%h d_out=%h rdata=%h expected zeros", a, d_out, rsp_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_read();
        int sl, rc, sf; logic [7:0] rd; logic to, st, rdy;
        run_cmd(1'b0, 12'h400, 8'h00, 8'h5A, 0, sl, rc, sf, rd, to, st, rdy);
        tests_run++;
        if (sl !== 4) begin tests_failed++; $display("FAIL read_strobe_len: got %0d expected 4", sl); end
        tests_run++;
        if (sf !== 1) begin tests_failed++; $display("FAIL read_sel_fall: got %0d expected 1", sf); end
        tests_run++;
        if (rc !== 9) begin tests_failed++; $display("FAIL read_rsp_cycle: got %0d expected 9", rc); end
        tests_run++;
        if ({rd, to} !== {8'h5A, 1'b0}) begin
            tests_failed++; $display("FAIL read_rsp: got rdata=%h tout=%b expected 5a/0", rd, to);
        end
        tests_run++;
        if ({st, rdy} !== 2'b11) begin
            tests_failed++; $display("FAIL read_stable_ready: got stable=%b ready=%b expected 1/1", st, rdy);
        end
    endtask

    task automatic test_write();
        int sl, rc, sf; logic [7:0] rd; logic to, st, rdy;
        run_cmd(1'b1, 12'h2C0, 8'hA7, 8'h33, 0, sl, rc, sf, rd, to, st, rdy);
        tests_run++;
        if (sl !== 4) begin tests_failed++; $display("FAIL write_strobe_len: got %0d expected 4", sl); end
        tests_run++;
        if (rc !== 9) begin tests_failed++; $display("FAIL write_rsp_cycle: got %0d expected 9", rc); end
        tests_run++;
        if (st !== 1'b1) begin
            tests_failed++; $display("FAIL write_bus_stable: got %b expected 1 (a/rnw/d_oe/d_out)", st);
        end
        tests_run++;
        if ({rd, to} !== {8'h5A, 1'b0}) begin
            tests_failed++; $display("FAIL write_rdata_kept: got rdata=%h tout=%b expected 5a/0", rd, to);
        end
    endtask

    task automatic test_timeout();
        int sl, rc, sf; logic [7:0] rd; logic to, st, rdy;
        run_cmd(1'b0, 12'h111, 8'h00, 8'h12, 1000, sl, rc, sf, rd, to, st, rdy);
        tests_run++;
        if (sl !== 64) begin tests_failed++; $display("FAIL timeout_strobe_len: got %0d expected 64", sl); end
        tests_run++;
        if (rc !== 69) begin tests_failed++; $display("FAIL timeout_rsp_cycle: got %0d expected 69", rc); end
        tests_run++;
        if ({rd, to} !== {8'hFF, 1'b1}) begin
            tests_failed++; $display("FAIL timeout_rsp: got rdata=%h tout=%b expected ff/1", rd, to);
        end
    endtask

    task automatic test_gt_stretch();
        int sl, rc, sf; logic [7:0] rd; logic to, st, rdy;
        run_cmd(1'b0, 12'h0F3, 8'h00, 8'h3C, 6, sl, rc, sf, rd, to, st, rdy);
        tests_run++;
        if (sl !== 7) begin tests_failed++; $display("FAIL stretch_strobe_len: got %0d expected 7", sl); end
        tests_run++;
        if (rc !== 12) begin tests_failed++; $display("FAIL stretch_rsp_cycle: got %0d expected 12", rc); end
        tests_run++;
        if ({rd, to} !== {8'h3C, 1'b0}) begin
            tests_failed++; $display("FAIL stretch_rsp: got rdata=%h tout=%b expected 3c/0", rd, to);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sel_seen;
        int rsp1, rsp2;
        sel_seen  = 3'bxxx;
        rsp1      = -1;
        rsp2      = -1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h345;
        cmd_wdata = 8'h00;
        d_in      = 8'hC3;
        gt        = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_write = 1'b1;
                cmd_addr  = 12'h346;
                cmd_wdata = 8'h96;
            end
            if (k == 8)  sel_seen[2] = nioc_sel;
            if (k == 9)  sel_seen[1] = nioc_sel;
            if (k == 10) begin
                sel_seen[0] = nioc_sel;
                cmd_valid   = 1'b0;
            end
            if (rsp_valid && rsp1 < 0) begin
                rsp1 = k;
                tests_run++;
                if ({cmd_ready, rsp_rdata} !== {1'b1, 8'hC3}) begin
                    tests_failed++;
                    $display("FAIL b2b_first_rsp: got ready=%b rdata=%h expected 1/c3", cmd_ready, rsp_rdata);
                end
            end else if (rsp_valid && rsp2 < 0) begin
                rsp2 = k;
                break;
            end
        end
        tests_run++;
        if (rsp1 !== 9) begin tests_failed++; $display("FAIL b2b_rsp1_cycle: got %0d expected 9", rsp1); end
        tests_run++;
        if (sel_seen !== 3'b010) begin
            tests_failed++; $display("FAIL b2b_sel_gap: got %b expected 010 (cycles 8..10)", sel_seen);
        end
        tests_run++;
        if (rsp2 !== 18) begin tests_failed++; $display("FAIL b2b_rsp2_cycle: got %0d expected 18", rsp2); end
        tests_run++;
        if (a !== 12'h346 || d_out !== 8'h96) begin
            tests_failed++; $display("FAIL b2b_second_cmd: got a=%h d_out=%h expected 346/96", a, d_out);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int sl, rc, sf; logic [7:0] rd; logic to, st, rdy;
        int stray;
        stray     = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h7AB;
        d_in      = 8'hE1;
        gt        = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        tests_run++;
        if (nre !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_in_strobe: got nre=%b expected 0", nre); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({cmd_ready, nioc_sel, nre, nwe, rnw, d_oe, rsp_valid, rsp_timeout} !== 8'b1111_1000) begin
            tests_failed++;
            $display("FAIL rst_mid_ctrl: got %b expected 11111000",
                     {cmd_ready, nioc_sel, nre, nwe, rnw, d_oe, rsp_valid, rsp_timeout});
        end
        tests_run++;
        if ({a, d_out, rsp_rdata} !== 28'h0) begin
            tests_failed++; $display("FAIL rst_mid_data: got a=%h d_out=%h rdata=%h expected zeros", a, d_out, rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        tests_run++;
        if (stray !== 0) begin tests_failed++; $display("FAIL rst_mid_no_rsp: got %0d pulses expected 0", stray); end
        run_cmd(1'b0, 12'h055, 8'h00, 8'h81, 0, sl, rc, sf, rd, to, st, rdy);
        tests_run++;
        if (rc !== 9 || rd !== 8'h81) begin
            tests_failed++; $display("FAIL rst_mid_recover: got cycle=%0d rdata=%h expected 9/81", rc, rd);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_gt_stretch();
        test_back_to_back();
        test_reset_mid_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
